// File: rtl/trace_line_checker.sv
// trace_line_checker
//   Byte-serial checker and field extractor for CPU trace lines, one character
//   per clock:
//     register line  ^<time>@<pc>: $<reg> <= <data>#
//     memory line    ^<time>@<pc>: *<addr> <= <data>#
//   Fields are shifted into shadow registers while the line streams in.
//   Outputs change only when a complete, semantically legal line is accepted.
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   char         ASCII input character, one per cycle
//   format_type  00 none/error, 01 register line, 10 memory line (1 cycle)
//   sem_err      1-cycle pulse: syntax ok, but register number or pc illegal
//   pc_o         pc of the last accepted line
//   addr_o       register number (zero-extended) or memory address
//   data_o       data of the last accepted line
//   line_count   accepted-line count, saturating at all-ones
module trace_line_checker #(
    parameter int unsigned TIME_DIGITS = 4,
    parameter int unsigned HEX_DIGITS  = 8,
    parameter int unsigned REG_DIGITS  = 4,
    parameter int unsigned REG_MAX     = 31,
    parameter bit          ALLOW_UPPER = 1'b0,
    parameter bit          PC_CHECK    = 1'b0,
    parameter logic [63:0] PC_LO       = 64'h3000,
    parameter logic [63:0] PC_HI       = 64'h6ffc,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              char,
    output logic [1:0]              format_type,
    output logic                    sem_err,
    output logic [4*HEX_DIGITS-1:0] pc_o,
    output logic [4*HEX_DIGITS-1:0] addr_o,
    output logic [4*HEX_DIGITS-1:0] data_o,
    output logic [CNT_W-1:0]        line_count
);

    localparam int unsigned AW = 4 * HEX_DIGITS;
    localparam logic [7:0]  TD = 8'(TIME_DIGITS);
    localparam logic [7:0]  HD = 8'(HEX_DIGITS);
    localparam logic [7:0]  RD = 8'(REG_DIGITS);

    typedef enum logic [3:0] {
        ST_IDLE, ST_TIME, ST_AT, ST_PC, ST_COLON, ST_SP1, ST_TYPE, ST_REG,
        ST_ADDR, ST_SP2, ST_LT, ST_EQ, ST_SP3, ST_DATA, ST_DONE
    } state_t;

    state_t        state, state_next, resync_state;
    logic [7:0]    cnt, cnt_next;
    logic [AW-1:0] pc_sh, addr_sh, data_sh;
    logic [31:0]   reg_val, reg_next;
    logic          reg_bad, is_mem, pc_bad;
    logic          is_dec, is_hex;
    logic [3:0]    nib;
    logic          shift_pc, shift_addr, shift_data, reg_start, reg_dig, mem_start, line_end;

    // Character classification and nibble value.
    always_comb begin
        is_dec = (char >= "0") && (char <= "9");
        is_hex = 1'b0;
        nib    = '0;
        if (is_dec) begin
            is_hex = 1'b1;
            nib    = 4'(char - "0");
        end else if ((char >= "a") && (char <= "f")) begin
            is_hex = 1'b1;
            nib    = 4'(char - "a" + 8'd10);
        end else if (ALLOW_UPPER && (char >= "A") && (char <= "F")) begin
            is_hex = 1'b1;
            nib    = 4'(char - "A" + 8'd10);
        end
    end

    // Only values still within REG_MAX are accumulated, so 32 bits never wrap.
    assign reg_next = reg_val * 32'd10 + {28'd0, nib};

    assign pc_bad = PC_CHECK && ((pc_sh[1:0] != 2'b00) ||
                                 (64'(pc_sh) < PC_LO) || (64'(pc_sh) > PC_HI));

    // Any unexpected character: '^' restarts a line, anything else drops it.
    assign resync_state = (char == "^") ? ST_TIME : ST_IDLE;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        shift_pc   = 1'b0;
        shift_addr = 1'b0;
        shift_data = 1'b0;
        reg_start  = 1'b0;
        reg_dig    = 1'b0;
        mem_start  = 1'b0;
        line_end   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                state_next = resync_state;
                cnt_next   = '0;
            end
            ST_TIME: begin
                if (is_dec) begin
                    if (cnt == TD) state_next = ST_IDLE;
                    else           cnt_next   = cnt + 8'd1;
                end else if ((char == "@") && (cnt != 8'd0)) begin
                    state_next = ST_PC;
                    cnt_next   = '0;
                end else begin
                    state_next = resync_state;
                    cnt_next   = '0;
                end
            end
            ST_PC: begin
                if (is_hex) begin
                    if (cnt == HD) state_next = ST_IDLE;
                    else begin
                        cnt_next = cnt + 8'd1;
                        shift_pc = 1'b1;
                    end
                end else if ((char == ":") && (cnt == HD)) begin
                    state_next = ST_SP1;
                end else begin
                    state_next = resync_state;
                    cnt_next   = '0;
                end
            end
            ST_SP1: begin
                cnt_next = '0;
                if (char == "$") begin
                    state_next = ST_REG;
                    reg_start  = 1'b1;
                end else if (char == "*") begin
                    state_next = ST_ADDR;
                    mem_start  = 1'b1;
                end else if (char != " ") begin
                    state_next = resync_state;
                end
            end
            ST_REG: begin
                if (is_dec) begin
                    if (cnt == RD) state_next = ST_IDLE;
                    else begin
                        cnt_next = cnt + 8'd1;
                        reg_dig  = 1'b1;
                    end
                end else if ((char == " ") && (cnt != 8'd0)) begin
                    state_next = ST_SP2;
                end else if ((char == "<") && (cnt != 8'd0)) begin
                    state_next = ST_LT;
                end else begin
                    state_next = resync_state;
                    cnt_next   = '0;
                end
            end
            ST_ADDR: begin
                if (is_hex) begin
                    if (cnt == HD) state_next = ST_IDLE;
                    else begin
                        cnt_next   = cnt + 8'd1;
                        shift_addr = 1'b1;
                    end
                end else if ((char == " ") && (cnt == HD)) begin
                    state_next = ST_SP2;
                end else if ((char == "<") && (cnt == HD)) begin
                    state_next = ST_LT;
                end else begin
                    state_next = resync_state;
                    cnt_next   = '0;
                end
            end
            ST_SP2: begin
                cnt_next = '0;
                if (char == "<")      state_next = ST_LT;
                else if (char != " ") state_next = resync_state;
            end
            ST_LT: begin
                cnt_next = '0;
                if (char == "=") state_next = ST_EQ;
                else             state_next = resync_state;
            end
            ST_EQ, ST_SP3: begin
                if (char == " ") begin
                    state_next = ST_SP3;
                    cnt_next   = '0;
                end else if (is_hex) begin
                    state_next = ST_DATA;
                    cnt_next   = 8'd1;
                    shift_data = 1'b1;
                end else begin
                    state_next = resync_state;
                    cnt_next   = '0;
                end
            end
            ST_DATA: begin
                if (is_hex) begin
                    if (cnt == HD) state_next = ST_IDLE;
                    else begin
                        cnt_next   = cnt + 8'd1;
                        shift_data = 1'b1;
                    end
                end else if ((char == "#") && (cnt == HD)) begin
                    state_next = ST_DONE;
                    line_end   = 1'b1;
                end else begin
                    state_next = resync_state;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pc_sh       <= '0;
            addr_sh     <= '0;
            data_sh     <= '0;
            reg_val     <= '0;
            reg_bad     <= 1'b0;
            is_mem      <= 1'b0;
            format_type <= '0;
            sem_err     <= 1'b0;
            pc_o        <= '0;
            addr_o      <= '0;
            data_o      <= '0;
            line_count  <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            format_type <= '0;
            sem_err     <= 1'b0;
            if (shift_pc)   pc_sh   <= {pc_sh[AW-5:0], nib};
            if (shift_addr) addr_sh <= {addr_sh[AW-5:0], nib};
            if (shift_data) data_sh <= {data_sh[AW-5:0], nib};
            if (reg_start) begin
                reg_val <= '0;
                reg_bad <= 1'b0;
                is_mem  <= 1'b0;
            end
            if (mem_start) begin
                reg_bad <= 1'b0;
                is_mem  <= 1'b1;
            end
            if (reg_dig && !reg_bad) begin
                if (reg_next > REG_MAX) reg_bad <= 1'b1;
                else                    reg_val <= reg_next;
            end
            if (line_end) begin
                if (reg_bad || pc_bad) begin
                    sem_err <= 1'b1;
                end else begin
                    format_type <= is_mem ? 2'b10 : 2'b01;
                    pc_o        <= pc_sh;
                    addr_o      <= is_mem ? addr_sh : AW'(reg_val);
                    data_o      <= data_sh;
                    if (line_count != '1) line_count <= line_count + CNT_W'(1);
                end
            end
            if (state == ST_DONE) begin
                reg_bad <= 1'b0;
                is_mem  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trace_line_checker.sv
module tb_trace_line_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  char = 8'h00;
    logic [1:0]  ft_a, ft_b;
    logic        sem_a, sem_b;
    logic [31:0] pc_a, addr_a, data_a, pc_b, addr_b, data_b;
    logic [15:0] cnt_a;
    logic [2:0]  cnt_b;

    always #5 clk = ~clk;

    trace_line_checker dut_a (
        .clk(clk), .reset(reset), .char(char), .format_type(ft_a), .sem_err(sem_a),
        .pc_o(pc_a), .addr_o(addr_a), .data_o(data_a), .line_count(cnt_a)
    );

    trace_line_checker #(.ALLOW_UPPER(1'b1), .PC_CHECK(1'b1), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .char(char), .format_type(ft_b), .sem_err(sem_b),
        .pc_o(pc_b), .addr_o(addr_b), .data_o(data_b), .line_count(cnt_b)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: every '^' starts a fresh line; on '#' the text since the
    // last '^' is parsed against the grammar as a whole string.
    string       lbuf = "";
    bit          lvalid = 1'b0;
    logic [1:0]  m_ft[2];
    logic        m_sem[2];
    logic [31:0] m_pc[2], m_addr[2], m_data[2];
    int unsigned m_cnt[2];

    function automatic logic [7:0] ch(input string s, input int i);
        return (i < s.len()) ? s[i] : 8'h00;
    endfunction

    function automatic int dec_run(input string s, inout int i, output longint unsigned v);
        int n = 0;
        v = 0;
        while (ch(s, i) >= "0" && ch(s, i) <= "9") begin
            v = v * 10 + longint'(ch(s, i) - "0");
            i++; n++;
        end
        return n;
    endfunction

    function automatic int hex_run(input string s, inout int i, input bit up, output logic [31:0] v);
        int n = 0;
        logic [7:0] c;
        v = 0;
        forever begin
            c = ch(s, i);
            if (c >= "0" && c <= "9")            v = {v[27:0], 4'(c - "0")};
            else if (c >= "a" && c <= "f")       v = {v[27:0], 4'(c - "a" + 8'd10)};
            else if (up && c >= "A" && c <= "F") v = {v[27:0], 4'(c - "A" + 8'd10)};
            else break;
            i++; n++;
        end
        return n;
    endfunction

    // 0 = syntax error, 1 = accepted, 2 = syntax ok but semantically illegal
    function automatic int parse_line(input string s, input bit up, input bit pcc,
                                      output logic [1:0] ft, output logic [31:0] pc,
                                      output logic [31:0] ad, output logic [31:0] dt);
        int i = 0;
        int n;
        longint unsigned v;
        bit bad_reg = 1'b0;
        ft = 0; pc = 0; ad = 0; dt = 0;
        n = dec_run(s, i, v);
        if (n < 1 || n > 4) return 0;
        if (ch(s, i) != "@") return 0;
        i++;
        if (hex_run(s, i, up, pc) != 8) return 0;
        if (ch(s, i) != ":") return 0;
        i++;
        while (ch(s, i) == " ") i++;
        if (ch(s, i) == "$") begin
            i++;
            n = dec_run(s, i, v);
            if (n < 1 || n > 4) return 0;
            ft = 2'b01;
            ad = v[31:0];
            bad_reg = (v > 31);
        end else if (ch(s, i) == "*") begin
            i++;
            if (hex_run(s, i, up, ad) != 8) return 0;
            ft = 2'b10;
        end else return 0;
        while (ch(s, i) == " ") i++;
        if (ch(s, i) != "<") return 0;
        i++;
        if (ch(s, i) != "=") return 0;
        i++;
        while (ch(s, i) == " ") i++;
        if (hex_run(s, i, up, dt) != 8) return 0;
        if (i != s.len()) return 0;
        if (bad_reg || (pcc && (pc[1:0] != 2'b00 || pc < 32'h3000 || pc > 32'h6ffc))) return 2;
        return 1;
    endfunction

    task automatic model_step(input logic [7:0] c, input bit rst);
        int r;
        logic [1:0] ft;
        logic [31:0] pc, ad, dt;
        for (int k = 0; k < 2; k++) begin
            m_ft[k] = 0;
            m_sem[k] = 0;
        end
        if (rst) begin
            lvalid = 0;
            for (int k = 0; k < 2; k++) begin
                m_pc[k] = 0; m_addr[k] = 0; m_data[k] = 0; m_cnt[k] = 0;
            end
        end else if (c == "^") begin
            lbuf = "";
            lvalid = 1;
        end else if (c == "#") begin
            if (lvalid) begin
                for (int k = 0; k < 2; k++) begin
                    r = parse_line(lbuf, k == 1, k == 1, ft, pc, ad, dt);
                    if (r == 1) begin
                        m_ft[k] = ft; m_pc[k] = pc; m_addr[k] = ad; m_data[k] = dt;
                        if (m_cnt[k] < ((k == 0) ? 65535 : 7)) m_cnt[k]++;
                    end else if (r == 2) begin
                        m_sem[k] = 1;
                    end
                end
            end
            lvalid = 0;
        end else if (lvalid) begin
            lbuf = $sformatf("%s%c", lbuf, c);
        end
    endtask

    task automatic step(input logic [7:0] c, input bit rst);
        @(negedge clk);
        char = c;
        reset = rst;
        model_step(c, rst);
        @(posedge clk);
        #1;
        check("ft_a", ft_a, m_ft[0]);     check("ft_b", ft_b, m_ft[1]);
        check("sem_a", sem_a, m_sem[0]);  check("sem_b", sem_b, m_sem[1]);
        check("pc_a", pc_a, m_pc[0]);     check("pc_b", pc_b, m_pc[1]);
        check("addr_a", addr_a, m_addr[0]); check("addr_b", addr_b, m_addr[1]);
        check("data_a", data_a, m_data[0]); check("data_b", data_b, m_data[1]);
        check("cnt_a", cnt_a, m_cnt[0]);  check("cnt_b", cnt_b, m_cnt[1]);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(s[i], 1'b0);
    endtask

    function automatic string spaces();
        string t = "";
        int n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) t = {t, " "};
        return t;
    endfunction

    function automatic logic [7:0] junk();
        string a = "0123456789abcdefABCDEF^@:$*<=# xZ";
        return a[$urandom_range(0, a.len() - 1)];
    endfunction

    function automatic string hex_field(input logic [31:0] v);
        string t = $sformatf("%08h", v);
        if ($urandom_range(0, 7) == 0) t = t.toupper();
        if ($urandom_range(0, 15) == 0) t = {t, "0"};
        else if ($urandom_range(0, 15) == 0) t = t.substr(1, 7);
        return t;
    endfunction

    function automatic string gen_line();
        string s = "^";
        string t;
        logic [31:0] v;
        int n, p;
        n = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(1, 4);
        for (int i = 0; i < n; i++) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
        case ($urandom_range(0, 3))
            0: v = 32'h3000 + 4 * $urandom_range(0, 'hfff);
            1: v = 32'h3000 + 4 * $urandom_range(0, 'hffe) + $urandom_range(1, 3);
            2: v = $urandom;
            default: case ($urandom_range(0, 3))
                0: v = 32'h2ffc;
                1: v = 32'h3000;
                2: v = 32'h6ffc;
                default: v = 32'h7000;
            endcase
        endcase
        s = {s, "@", hex_field(v), ":", spaces()};
        if ($urandom_range(0, 1) == 0) begin
            t = $sformatf("%0d", $urandom_range(0, 40));
            n = $urandom_range(1, 5);
            while (t.len() < n) t = {"0", t};
            s = {s, "$", t};
        end else begin
            s = {s, "*", hex_field($urandom)};
        end
        s = {s, spaces(), "<=", spaces(), hex_field($urandom)};
        if ($urandom_range(0, 9) == 0) begin
            p = $urandom_range(1, s.len() - 1);
            s = $sformatf("%s%c%s", s.substr(0, p - 1), junk(), s.substr(p + 1, s.len() - 1));
        end
        if ($urandom_range(0, 19) != 0) s = {s, "#"};
        return s;
    endfunction

    initial begin
        int c0;
        string s;
        int rpos, nj;
        for (int k = 0; k < 2; k++) begin
            m_ft[k] = 0; m_sem[k] = 0; m_pc[k] = 0; m_addr[k] = 0; m_data[k] = 0; m_cnt[k] = 0;
        end
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        check("rst_ft", ft_a, 2'b00);
        check("rst_cnt", cnt_a, 16'd0);

        send_str("^12@00003000: $5 <= 0000abcd#");
        check("t1_ft", ft_a, 2'b01);
        check("t1_pc", pc_a, 32'h3000);
        check("t1_addr", addr_a, 32'h5);
        check("t1_data", data_a, 32'habcd);
        check("t1_cnt", cnt_a, 16'd1);

        send_str("^7@00003004:*0000001c<=12345678#");
        check("t2_ft", ft_a, 2'b10);
        check("t2_addr", addr_a, 32'h1c);
        check("t2_data", data_a, 32'h12345678);
        check("t2_cnt", cnt_a, 16'd2);
        step(" ", 1'b0);
        check("t2_ft_clr", ft_a, 2'b00);

        send_str("^12345@00003000: $1 <= 00000001#");
        check("t3_ovf_ft", ft_a, 2'b00);
        send_str("^1@00003008: $0 <= 00000000#");
        check("t3_ft", ft_a, 2'b01);
        check("t3_cnt", cnt_a, 16'd3);

        c0 = int'(cnt_a);
        send_str("^3@00003000: $32 <= 00000001#");
        check("t4_sem_a", sem_a, 1'b1);
        check("t4_sem_b", sem_b, 1'b1);
        check("t4_ft", ft_a, 2'b00);
        check("t4_cnt", cnt_a, 64'(c0));
        send_str("^3@00003002: $1 <= 00000001#");
        check("t4_pcbad_b", sem_b, 1'b1);
        check("t4_pc_a", ft_a, 2'b01);

        send_str("^3@00003A00: $1 <= 00000001#");
        check("t5_ft_a", ft_a, 2'b00);
        check("t5_ft_b", ft_b, 2'b01);
        check("t5_pc_b", pc_b, 32'h3a00);

        send_str("^12@0000");
        step(" ", 1'b1);
        send_str("3000: $5 <= 0000abcd#");
        check("t6_rst_ft", ft_a, 2'b00);
        check("t6_rst_cnt", cnt_a, 16'd0);
        send_str("^^1@00003000: $1 <= 00000001#");
        check("t6_dbl_ft", ft_a, 2'b01);
        send_str("^2@00003004: $2 <= 00000002#");
        check("t6_b2b_ft", ft_a, 2'b01);
        check("t6_b2b_data", data_a, 32'h2);

        for (int L = 0; L < 300; L++) begin
            s = gen_line();
            rpos = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, s.len() - 1)) : -1;
            nj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            for (int j = 0; j < nj; j++) step(junk(), 1'b0);
            for (int i = 0; i < s.len(); i++) step(s[i], i == rpos);
        end
        for (int i = 0; i < 3; i++) step(" ", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
